// File: rtl/pocq.sv
// Point-of-coherence request queue: credit-managed CHI RXREQ FIFO that feeds
// the oldest stored request to the SLC/SF lookup pipeline.

package pocq_pkg;
    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [11:0] txn_id;
        logic [6:0]  opcode;
        logic [47:0] addr;
    } reqflit_t;

    localparam logic [6:0] OPC_REQLCRDRETURN = 7'h00;
endpackage

module pocq
    import pocq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxreqflitv,
    input  reqflit_t         rxreqflit,
    output logic             rxreqlcrdv,
    output reqflit_t         rxreq_pocq_first_entry,
    output logic             rxreq_pocq_first_entry_v,
    input  logic             rxreq_pocq_deq,
    output logic [CNT_W-1:0] pocq_count,
    output logic             pocq_overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    reqflit_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_granted;
    logic [CNT_W-1:0] r_pending;
    logic             r_lcrdv;
    logic             r_overflow;

    logic             w_has_credit;
    logic             w_enq;
    logic             w_ret;
    logic             w_drop;
    logic             w_deq;
    logic             w_issue;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_INIT: w_state_next = ST_RUN;
            ST_RUN:  w_issue      = (r_pending != '0);
            default: w_state_next = ST_INIT;
        endcase
    end

    // A flit is only legal while the requester holds a credit; otherwise it is dropped.
    assign w_has_credit = (r_granted != '0);
    assign w_enq  = rxreqflitv && w_has_credit && (rxreqflit.opcode != OPC_REQLCRDRETURN);
    assign w_ret  = rxreqflitv && w_has_credit && (rxreqflit.opcode == OPC_REQLCRDRETURN);
    assign w_drop = rxreqflitv && !w_has_credit;
    assign w_deq  = rxreq_pocq_deq && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_granted  <= '0;
            r_pending  <= CNT_W'(DEPTH);
            r_lcrdv    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lcrdv    <= w_issue;
            // Each credit pool moves by the net of all same-cycle events, preserving the total.
            r_count    <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            r_granted  <= r_granted + CNT_W'(w_issue) - CNT_W'(w_enq) - CNT_W'(w_ret);
            r_pending  <= r_pending - CNT_W'(w_issue) + CNT_W'(w_ret) + CNT_W'(w_deq);
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= rxreqflit;
        end
    end

    assign rxreqlcrdv               = r_lcrdv;
    assign rxreq_pocq_first_entry   = r_mem[r_rd_ptr];
    assign rxreq_pocq_first_entry_v = (r_count != '0);
    assign pocq_count               = r_count;
    assign pocq_overflow_err        = r_overflow;

endmodule

// File: tb/tb_pocq.sv
// Directed bench for pocq at DEPTH=4: credit handout, fill, overflow,
// credit return, concurrent enqueue/dequeue across wrap, and mid-run reset.

module tb_pocq;
    import pocq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam logic [6:0] OP_RU  = 7'h07;
    localparam logic [6:0] OP_RET = 7'h00;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rxreqflitv = 1'b0;
    reqflit_t         rxreqflit = '0;
    logic             rxreqlcrdv;
    reqflit_t         rxreq_pocq_first_entry;
    logic             rxreq_pocq_first_entry_v;
    logic             rxreq_pocq_deq = 1'b0;
    logic [CNT_W-1:0] pocq_count;
    logic             pocq_overflow_err;

    int checks = 0;
    int errors = 0;

    pocq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .rxreqflitv               (rxreqflitv),
        .rxreqflit                (rxreqflit),
        .rxreqlcrdv               (rxreqlcrdv),
        .rxreq_pocq_first_entry   (rxreq_pocq_first_entry),
        .rxreq_pocq_first_entry_v (rxreq_pocq_first_entry_v),
        .rxreq_pocq_deq           (rxreq_pocq_deq),
        .pocq_count               (pocq_count),
        .pocq_overflow_err        (pocq_overflow_err)
    );

    always #5 clk = ~clk;

    function automatic reqflit_t mk(input logic [6:0] op, input logic [11:0] txn);
        reqflit_t f;
        f.qos    = 4'h3;
        f.tgt_id = 7'h11;
        f.src_id = 7'h22;
        f.txn_id = txn;
        f.opcode = op;
        f.addr   = {36'hABC000000, txn};
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_dut;
        rst_n = 1'b0;
        rxreqflitv = 1'b0;
        rxreq_pocq_deq = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        repeat (7) tick;
    endtask

    task automatic send(input logic [6:0] op, input logic [11:0] txn);
        rxreqflitv = 1'b1;
        rxreqflit  = mk(op, txn);
        $display("tx flit op=%h txn=%h", op, txn);
        tick;
        rxreqflitv = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_l;
        rst_n = 1'b0;
        tick;
        tick;
        checks++; if (pocq_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pocq_count); end
        checks++; if (rxreq_pocq_first_entry_v !== 1'b0) begin errors++; $display("FAIL reset_v got %b want 0", rxreq_pocq_first_entry_v); end
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL reset_lcrdv got %b want 0", rxreqlcrdv); end
        checks++; if (pocq_overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", pocq_overflow_err); end
        rst_n = 1'b1;
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL crd_cycle0 got %b want 0", rxreqlcrdv); end
        for (int k = 1; k <= 7; k++) begin
            tick;
            exp_l = (k >= 2 && k <= 5);
            checks++; if (rxreqlcrdv !== exp_l) begin errors++; $display("FAIL crd_cycle%0d got %b want %b", k, rxreqlcrdv, exp_l); end
        end
        $display("test_reset done");
    endtask

    task automatic test_fill;
        init_dut;
        for (int i = 0; i < 4; i++) begin
            send(OP_RU, 12'hA00 + 12'(i));
            checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL fill_lcrdv%0d got %b want 0", i, rxreqlcrdv); end
            if (i == 0) begin
                checks++; if (rxreq_pocq_first_entry_v !== 1'b1) begin errors++; $display("FAIL fill_latency_v got %b want 1", rxreq_pocq_first_entry_v); end
                checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, 12'hA00)) begin errors++; $display("FAIL fill_latency_first got %h want %h", rxreq_pocq_first_entry, mk(OP_RU, 12'hA00)); end
            end
        end
        checks++; if (pocq_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", pocq_count); end
        checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, 12'hA00)) begin errors++; $display("FAIL fill_first got %h want A", rxreq_pocq_first_entry); end
        rxreq_pocq_deq = 1'b1;
        tick;
        rxreq_pocq_deq = 1'b0;
        checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, 12'hA01)) begin errors++; $display("FAIL deq_first got %h want %h", rxreq_pocq_first_entry, mk(OP_RU, 12'hA01)); end
        checks++; if (pocq_count !== 3'd3) begin errors++; $display("FAIL deq_count got %0d want 3", pocq_count); end
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL deq_lcrdv_early got %b want 0", rxreqlcrdv); end
        tick;
        checks++; if (rxreqlcrdv !== 1'b1) begin errors++; $display("FAIL deq_lcrdv_pulse got %b want 1", rxreqlcrdv); end
        tick;
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL deq_lcrdv_end got %b want 0", rxreqlcrdv); end
        $display("test_fill done");
    endtask

    task automatic test_overflow;
        init_dut;
        for (int i = 0; i < 4; i++) send(OP_RU, 12'hA00 + 12'(i));
        checks++; if (pocq_overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", pocq_overflow_err); end
        send(OP_RU, 12'hE00);
        checks++; if (pocq_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", pocq_count); end
        checks++; if (pocq_overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", pocq_overflow_err); end
        tick;
        tick;
        checks++; if (pocq_overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", pocq_overflow_err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, 12'hA00 + 12'(i))) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, rxreq_pocq_first_entry, mk(OP_RU, 12'hA00 + 12'(i))); end
            rxreq_pocq_deq = 1'b1;
            tick;
            rxreq_pocq_deq = 1'b0;
        end
        checks++; if (rxreq_pocq_first_entry_v !== 1'b0) begin errors++; $display("FAIL empty_v got %b want 0", rxreq_pocq_first_entry_v); end
        rxreq_pocq_deq = 1'b1;
        tick;
        rxreq_pocq_deq = 1'b0;
        checks++; if (pocq_count !== 3'd0) begin errors++; $display("FAIL empty_deq_count got %0d want 0", pocq_count); end
        checks++; if (pocq_overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky2 got %b want 1", pocq_overflow_err); end
        $display("test_overflow done");
    endtask

    task automatic test_crd_return;
        init_dut;
        send(OP_RET, 12'h055);
        checks++; if (pocq_count !== 3'd0) begin errors++; $display("FAIL ret_count got %0d want 0", pocq_count); end
        checks++; if (rxreq_pocq_first_entry_v !== 1'b0) begin errors++; $display("FAIL ret_v got %b want 0", rxreq_pocq_first_entry_v); end
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL ret_lcrdv_early got %b want 0", rxreqlcrdv); end
        tick;
        checks++; if (rxreqlcrdv !== 1'b1) begin errors++; $display("FAIL ret_lcrdv_pulse got %b want 1", rxreqlcrdv); end
        tick;
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL ret_lcrdv_end got %b want 0", rxreqlcrdv); end
        for (int i = 0; i < 4; i++) send(OP_RU, 12'hD00 + 12'(i));
        checks++; if (pocq_count !== 3'd4) begin errors++; $display("FAIL ret_refill_count got %0d want 4", pocq_count); end
        checks++; if (pocq_overflow_err !== 1'b0) begin errors++; $display("FAIL ret_refill_ovf got %b want 0", pocq_overflow_err); end
        $display("test_crd_return done");
    endtask

    task automatic test_back_to_back;
        logic [11:0] q[$];
        init_dut;
        send(OP_RU, 12'hB00);
        send(OP_RU, 12'hB01);
        q.push_back(12'hB00);
        q.push_back(12'hB01);
        checks++; if (pocq_count !== 3'd2) begin errors++; $display("FAIL b2b_start_count got %0d want 2", pocq_count); end
        for (int i = 0; i < 6; i++) begin
            rxreqflitv     = 1'b1;
            rxreqflit      = mk(OP_RU, 12'hC00 + 12'(i));
            rxreq_pocq_deq = 1'b1;
            $display("tx enq+deq txn=%h", 12'hC00 + 12'(i));
            q.push_back(12'hC00 + 12'(i));
            void'(q.pop_front());
            tick;
            checks++; if (pocq_count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got %0d want 2", i, pocq_count); end
            checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, q[0])) begin errors++; $display("FAIL b2b_first%0d got %h want %h", i, rxreq_pocq_first_entry, mk(OP_RU, q[0])); end
        end
        rxreqflitv     = 1'b0;
        rxreq_pocq_deq = 1'b0;
        checks++; if (pocq_overflow_err !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", pocq_overflow_err); end
        while (q.size() > 0) begin
            checks++; if (rxreq_pocq_first_entry !== mk(OP_RU, q[0])) begin errors++; $display("FAIL b2b_drain got %h want %h", rxreq_pocq_first_entry, mk(OP_RU, q[0])); end
            void'(q.pop_front());
            rxreq_pocq_deq = 1'b1;
            tick;
            rxreq_pocq_deq = 1'b0;
        end
        checks++; if (pocq_count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", pocq_count); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid;
        logic exp_l;
        init_dut;
        for (int i = 0; i < 3; i++) send(OP_RU, 12'hF00 + 12'(i));
        checks++; if (pocq_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", pocq_count); end
        rst_n = 1'b0;
        tick;
        checks++; if (rxreq_pocq_first_entry_v !== 1'b0) begin errors++; $display("FAIL mid_v got %b want 0", rxreq_pocq_first_entry_v); end
        checks++; if (pocq_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", pocq_count); end
        rst_n = 1'b1;
        checks++; if (rxreqlcrdv !== 1'b0) begin errors++; $display("FAIL mid_crd_cycle0 got %b want 0", rxreqlcrdv); end
        for (int k = 1; k <= 7; k++) begin
            tick;
            exp_l = (k >= 2 && k <= 5);
            checks++; if (rxreqlcrdv !== exp_l) begin errors++; $display("FAIL mid_crd_cycle%0d got %b want %b", k, rxreqlcrdv, exp_l); end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset;
        test_fill;
        test_overflow;
        test_crd_return;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
